// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative HI/LO engine for the EXE stage of the MIPS pipeline.
// Executes MULTU/MULT (shift-add) and DIVU/DIV (restoring shift-subtract) over
// WIDTH iterations, then applies the sign fix-up. Hi/Lo can also be written
// directly (MTHI/MTLO) whenever the engine is not busy.
// Ports:
//   CLK, RST         clock, asynchronous active-high reset
//   Start, Op, A, B  operation request (Op: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV)
//   Flush            squash the in-flight operation
//   WE_Hi, WE_Lo, WD direct Hi/Lo writes (ignored while Busy)
//   Busy, Done       engine in RUN/FIX; one-cycle completion pulse
//   Div_By_Zero      pulses with Done when a divide had B=0 (Hi/Lo untouched)
//   Hi, Lo           product upper/lower half, or remainder/quotient
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Flush,
  input  logic             WE_Hi,
  input  logic             WE_Lo,
  input  logic [WIDTH-1:0] WD,
  output logic             Busy,
  output logic             Done,
  output logic             Div_By_Zero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W = (2*WIDTH)'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_r, state_s;

  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] acc_hi_r, acc_lo_r, opb_r;
  logic             is_div_r, neg_q_r, neg_r_r, zero_div_r;
  logic [WIDTH-1:0] hi_r, lo_r;
  logic             busy_r, done_r, dbz_r;

  logic             accept_s;
  logic             a_neg_s, b_neg_s;
  logic [WIDTH-1:0] a_abs_s, b_abs_s;
  logic [WIDTH:0]   mul_sum_s, div_sh_s, div_diff_s;
  logic [2*WIDTH-1:0] prod_s, prod_fix_s;
  logic [WIDTH-1:0] quo_fix_s, rem_fix_s, res_hi_s, res_lo_s;

  // A new operation may start only from a non-busy state, and Flush vetoes it.
  assign accept_s = Start & ~Flush & ((state_r == IDLE) | (state_r == DONE));

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = RUN;
        else          state_s = IDLE;
      end
      RUN: begin
        if (Flush)                 state_s = IDLE;
        else if (count_r == LAST)  state_s = FIX;
        else                       state_s = RUN;
      end
      FIX: begin
        if (Flush) state_s = IDLE;
        else       state_s = DONE;
      end
      DONE: begin
        if (accept_s) state_s = RUN;
        else          state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Operand magnitudes; only signed ops (Op[0]) look at the sign bits.
  always_comb begin
    a_neg_s = Op[0] & A[WIDTH-1];
    b_neg_s = Op[0] & B[WIDTH-1];
    if (a_neg_s) a_abs_s = ~A + ONE_W;
    else         a_abs_s = A;
    if (b_neg_s) b_abs_s = ~B + ONE_W;
    else         b_abs_s = B;
  end

  // One iteration step for each engine, plus the final sign correction.
  always_comb begin
    // Multiply: add multiplicand when the current multiplier LSB is set;
    // the (WIDTH+1)-bit sum keeps the carry that shifts into the top of Hi.
    if (acc_lo_r[0]) mul_sum_s = {1'b0, acc_hi_r} + {1'b0, opb_r};
    else             mul_sum_s = {1'b0, acc_hi_r};
    // Divide: shift the next dividend bit into the partial remainder and
    // trial-subtract; a set MSB of the difference means "restore".
    div_sh_s   = {acc_hi_r, acc_lo_r[WIDTH-1]};
    div_diff_s = div_sh_s - {1'b0, opb_r};

    prod_s = {acc_hi_r, acc_lo_r};
    if (neg_q_r) prod_fix_s = ~prod_s + ONE_2W;
    else         prod_fix_s = prod_s;
    if (neg_q_r) quo_fix_s = ~acc_lo_r + ONE_W;
    else         quo_fix_s = acc_lo_r;
    if (neg_r_r) rem_fix_s = ~acc_hi_r + ONE_W;
    else         rem_fix_s = acc_hi_r;

    if (is_div_r) begin
      res_hi_s = rem_fix_s;
      res_lo_s = quo_fix_s;
    end else begin
      res_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
      res_lo_s = prod_fix_s[WIDTH-1:0];
    end
  end

  // Working registers: load on accept, iterate while in RUN.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_r    <= {CW{1'b0}};
      acc_hi_r   <= {WIDTH{1'b0}};
      acc_lo_r   <= {WIDTH{1'b0}};
      opb_r      <= {WIDTH{1'b0}};
      is_div_r   <= 1'b0;
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
      zero_div_r <= 1'b0;
    end else if (accept_s) begin
      count_r    <= {CW{1'b0}};
      acc_hi_r   <= {WIDTH{1'b0}};
      acc_lo_r   <= a_abs_s;
      opb_r      <= b_abs_s;
      is_div_r   <= Op[1];
      neg_q_r    <= a_neg_s ^ b_neg_s;
      neg_r_r    <= a_neg_s;
      zero_div_r <= Op[1] & (B == {WIDTH{1'b0}});
    end else if (state_r == RUN) begin
      count_r <= count_r + CW'(1);
      if (is_div_r) begin
        if (div_diff_s[WIDTH]) begin
          acc_hi_r <= div_sh_s[WIDTH-1:0];
          acc_lo_r <= {acc_lo_r[WIDTH-2:0], 1'b0};
        end else begin
          acc_hi_r <= div_diff_s[WIDTH-1:0];
          acc_lo_r <= {acc_lo_r[WIDTH-2:0], 1'b1};
        end
      end else begin
        acc_hi_r <= mul_sum_s[WIDTH:1];
        acc_lo_r <= {mul_sum_s[0], acc_lo_r[WIDTH-1:1]};
      end
    end
  end

  // Architectural Hi/Lo: result write on FIX->DONE, direct writes when not busy.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hi_r <= {WIDTH{1'b0}};
      lo_r <= {WIDTH{1'b0}};
    end else if ((state_r == FIX) && !Flush && !zero_div_r) begin
      hi_r <= res_hi_s;
      lo_r <= res_lo_s;
    end else if (!busy_r) begin
      if (WE_Hi) hi_r <= WD;
      if (WE_Lo) lo_r <= WD;
    end
  end

  // Status outputs registered from the next state so they track it exactly.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
    end else begin
      busy_r <= (state_s == RUN) | (state_s == FIX);
      done_r <= (state_s == DONE);
      dbz_r  <= (state_s == DONE) & zero_div_r;
    end
  end

  assign Busy        = busy_r;
  assign Done        = done_r;
  assign Div_By_Zero = dbz_r;
  assign Hi          = hi_r;
  assign Lo          = lo_r;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit at WIDTH=32.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mul_div_unit;

  logic        CLK, RST, Start, Flush, WE_Hi, WE_Lo;
  logic [1:0]  Op;
  logic [31:0] A, B, WD;
  logic        Busy, Done, Div_By_Zero;
  logic [31:0] Hi, Lo;

  int n_checks = 0;
  int n_fail   = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Op(Op), .A(A), .B(B),
    .Flush(Flush), .WE_Hi(WE_Hi), .WE_Lo(WE_Lo), .WD(WD),
    .Busy(Busy), .Done(Done), .Div_By_Zero(Div_By_Zero), .Hi(Hi), .Lo(Lo)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Called at a falling edge: pulse Start for one cycle, then wait for Done.
  // lat = index of the cycle (1 = cycle right after the Start edge) where Done is seen.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    Start = 1'b1; Op = op; A = a; B = b;
    @(negedge CLK);
    Start = 1'b0;
    lat = 1;
    while (!Done && lat < 60) begin
      @(negedge CLK);
      lat++;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; Start = 1'b0; Flush = 1'b0; WE_Hi = 1'b0; WE_Lo = 1'b0;
    Op = 2'b00; A = 32'h0; B = 32'h0; WD = 32'h0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    n_checks++; if (Hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi got %h exp %h", Hi, 32'h0); end
    n_checks++; if (Lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo got %h exp %h", Lo, 32'h0); end
    n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", Busy); end
    n_checks++; if (Done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", Done); end
  endtask

  task automatic test_multu();
    int lat;
    Start = 1'b1; Op = 2'b00; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF;
    @(negedge CLK);
    Start = 1'b0;
    n_checks++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL multu_busy got %b exp 1", Busy); end
    lat = 1;
    while (!Done && lat < 60) begin
      @(negedge CLK);
      lat++;
    end
    n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL multu_latency got %0d exp 34", lat); end
    n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL multu_busy_done got %b exp 0", Busy); end
    n_checks++; if (Hi !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL multu_hi got %h exp %h", Hi, 32'hFFFFFFFE); end
    n_checks++; if (Lo !== 32'h00000001) begin n_fail++; $display("FAIL multu_lo got %h exp %h", Lo, 32'h00000001); end
    @(negedge CLK);
    n_checks++; if (Done !== 1'b0) begin n_fail++; $display("FAIL multu_done_pulse got %b exp 0", Done); end
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(2'b01, 32'hFFFFFFFD, 32'd5, lat);
    n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL mult_latency got %0d exp 34", lat); end
    n_checks++; if (Hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mult_hi got %h exp %h", Hi, 32'hFFFFFFFF); end
    n_checks++; if (Lo !== 32'hFFFFFFF1) begin n_fail++; $display("FAIL mult_lo got %h exp %h", Lo, 32'hFFFFFFF1); end
    // Still in the DONE cycle: start the next operation straight away.
    run_op(2'b00, 32'd7, 32'd9, lat);
    n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL b2b_latency got %0d exp 34", lat); end
    n_checks++; if (Hi !== 32'h0) begin n_fail++; $display("FAIL b2b_hi got %h exp %h", Hi, 32'h0); end
    n_checks++; if (Lo !== 32'd63) begin n_fail++; $display("FAIL b2b_lo got %h exp %h", Lo, 32'd63); end
    @(negedge CLK);
  endtask

  task automatic test_div();
    int lat;
    run_op(2'b11, 32'hFFFFFFF9, 32'd2, lat);
    n_checks++; if (Lo !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_neg_lo got %h exp %h", Lo, 32'hFFFFFFFD); end
    n_checks++; if (Hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_neg_hi got %h exp %h", Hi, 32'hFFFFFFFF); end
    @(negedge CLK);
    run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, lat);
    n_checks++; if (Lo !== 32'h80000000) begin n_fail++; $display("FAIL div_wrap_lo got %h exp %h", Lo, 32'h80000000); end
    n_checks++; if (Hi !== 32'h0) begin n_fail++; $display("FAIL div_wrap_hi got %h exp %h", Hi, 32'h0); end
    n_checks++; if (Div_By_Zero !== 1'b0) begin n_fail++; $display("FAIL div_wrap_flag got %b exp 0", Div_By_Zero); end
    @(negedge CLK);
    run_op(2'b10, 32'd100, 32'd7, lat);
    n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL divu_latency got %0d exp 34", lat); end
    n_checks++; if (Lo !== 32'd14) begin n_fail++; $display("FAIL divu_lo got %h exp %h", Lo, 32'd14); end
    n_checks++; if (Hi !== 32'd2) begin n_fail++; $display("FAIL divu_hi got %h exp %h", Hi, 32'd2); end
    @(negedge CLK);
  endtask

  task automatic test_div_zero();
    int lat;
    WE_Hi = 1'b1; WD = 32'h11;
    @(negedge CLK);
    WE_Hi = 1'b0; WE_Lo = 1'b1; WD = 32'h22;
    @(negedge CLK);
    WE_Lo = 1'b0;
    run_op(2'b10, 32'd5, 32'd0, lat);
    n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL dbz_latency got %0d exp 34", lat); end
    n_checks++; if (Div_By_Zero !== 1'b1) begin n_fail++; $display("FAIL dbz_flag got %b exp 1", Div_By_Zero); end
    n_checks++; if (Hi !== 32'h11) begin n_fail++; $display("FAIL dbz_hi got %h exp %h", Hi, 32'h11); end
    n_checks++; if (Lo !== 32'h22) begin n_fail++; $display("FAIL dbz_lo got %h exp %h", Lo, 32'h22); end
    @(negedge CLK);
    n_checks++; if (Div_By_Zero !== 1'b0) begin n_fail++; $display("FAIL dbz_pulse got %b exp 0", Div_By_Zero); end
  endtask

  task automatic test_flush();
    int seen;
    // Flush in cycle 10 of RUN; Hi/Lo still hold 0x11/0x22.
    Start = 1'b1; Op = 2'b00; A = 32'd3; B = 32'd4;
    @(negedge CLK);
    Start = 1'b0;
    repeat (9) @(negedge CLK);
    Flush = 1'b1;
    @(negedge CLK);
    Flush = 1'b0;
    n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got %b exp 0", Busy); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (Done) seen = 1;
      @(negedge CLK);
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL flush_no_done got %0d exp 0", seen); end
    n_checks++; if (Hi !== 32'h11) begin n_fail++; $display("FAIL flush_hi got %h exp %h", Hi, 32'h11); end
    n_checks++; if (Lo !== 32'h22) begin n_fail++; $display("FAIL flush_lo got %h exp %h", Lo, 32'h22); end

    // Reset mid-run, asserted and released between clock edges.
    Start = 1'b1; Op = 2'b00; A = 32'd3; B = 32'd4;
    @(negedge CLK);
    Start = 1'b0;
    repeat (9) @(negedge CLK);
    #1 RST = 1'b1;
    #1;
    n_checks++; if ({Busy, Done, Div_By_Zero} !== 3'b000) begin n_fail++; $display("FAIL rst_mid_flags got %b exp 000", {Busy, Done, Div_By_Zero}); end
    n_checks++; if (Hi !== 32'h0) begin n_fail++; $display("FAIL rst_mid_hi got %h exp %h", Hi, 32'h0); end
    n_checks++; if (Lo !== 32'h0) begin n_fail++; $display("FAIL rst_mid_lo got %h exp %h", Lo, 32'h0); end
    #1 RST = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (Done || Busy) seen = 1;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rst_mid_quiet got %0d exp 0", seen); end
  endtask

  task automatic test_busy_ignore();
    int lat;
    int seen;
    Start = 1'b1; Op = 2'b00; A = 32'd6; B = 32'd7;
    @(negedge CLK);
    Start = 1'b0;
    repeat (4) @(negedge CLK);
    Start = 1'b1; Op = 2'b10; A = 32'd9; B = 32'd3; WE_Lo = 1'b1; WD = 32'hABCD;
    @(negedge CLK);
    Start = 1'b0; WE_Lo = 1'b0;
    lat = 6;
    while (!Done && lat < 60) begin
      @(negedge CLK);
      lat++;
    end
    n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL busy_latency got %0d exp 34", lat); end
    n_checks++; if (Lo !== 32'd42) begin n_fail++; $display("FAIL busy_lo got %h exp %h", Lo, 32'd42); end
    n_checks++; if (Hi !== 32'h0) begin n_fail++; $display("FAIL busy_hi got %h exp %h", Hi, 32'h0); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (Done || Busy) seen = 1;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL busy_no_queue got %0d exp 0", seen); end
  endtask

  task automatic test_direct_write();
    WE_Hi = 1'b1; WE_Lo = 1'b1; WD = 32'h55;
    @(negedge CLK);
    WE_Hi = 1'b0; WE_Lo = 1'b0;
    n_checks++; if (Hi !== 32'h55) begin n_fail++; $display("FAIL dw_hi got %h exp %h", Hi, 32'h55); end
    n_checks++; if (Lo !== 32'h55) begin n_fail++; $display("FAIL dw_lo got %h exp %h", Lo, 32'h55); end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_back_to_back();
    test_div();
    test_div_zero();
    test_flush();
    test_busy_ignore();
    test_direct_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
